// File: rtl/core_ctrl_pkg.sv
// Shared control encodings for the multi-cycle core: opcodes, FSM states,
// datapath select codes and the instruction-class bundle.
package core_ctrl_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned SEL_W    = 2;

    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_R_ALU  = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I_ALU  = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_JALR     = 4'd10,
        S_JALR_PC  = 4'd11,
        S_BRANCH   = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_t;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [SEL_W-1:0] ALUOP_ADDI3 = 2'b11;

    typedef struct packed {
        logic load;
        logic store;
        logic r_alu;
        logic i_alu;
        logic addi3;
        logic jal;
        logic jalr;
        logic branch;
    } op_class_t;

endpackage

// File: rtl/opcode_class_dec.sv
// Combinational opcode classifier: one-hot instruction class plus legal flag.
module opcode_class_dec
    import core_ctrl_pkg::*;
#(
    parameter bit                  ADDI3_EN     = 1'b1,
    parameter logic [OPCODE_W-1:0] ADDI3_OPCODE = 7'b0000010
) (
    input  logic [OPCODE_W-1:0] op_code,
    output op_class_t           op_class,
    output logic                legal
);

    // The custom opcode takes precedence so a class stays one-hot.
    always_comb begin
        op_class       = '0;
        op_class.addi3 = ADDI3_EN && (op_code == ADDI3_OPCODE);
        if (!op_class.addi3) begin
            case (op_code)
                OP_LOAD:   op_class.load   = 1'b1;
                OP_STORE:  op_class.store  = 1'b1;
                OP_R_ALU:  op_class.r_alu  = 1'b1;
                OP_I_ALU:  op_class.i_alu  = 1'b1;
                OP_JAL:    op_class.jal    = 1'b1;
                OP_JALR:   op_class.jalr   = 1'b1;
                OP_BRANCH: op_class.branch = 1'b1;
                default:   ;
            endcase
        end
        legal = |op_class;
    end

endmodule

// File: rtl/multicycle_main_controller.sv
// Main-control FSM of the multi-cycle RISC-V core: sequences fetch, decode,
// execute, memory and writeback, Moore-decoding the datapath controls.
module multicycle_main_controller
    import core_ctrl_pkg::*;
#(
    parameter bit                  MEM_HANDSHAKE = 1'b1,
    parameter bit                  ADDI3_EN      = 1'b1,
    parameter logic [OPCODE_W-1:0] ADDI3_OPCODE  = 7'b0000010,
    parameter bit                  ILLEGAL_HALT  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] op_code,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                adr_src,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic [SEL_W-1:0]    result_src,
    output logic [SEL_W-1:0]    alu_src_a,
    output logic [SEL_W-1:0]    alu_src_b,
    output logic [SEL_W-1:0]    alu_op,
    output logic                branch,
    output logic                illegal
);

    state_t    state, state_next;
    op_class_t op_class;
    logic      legal;
    logic      rdy;
    logic      pc_update;

    opcode_class_dec #(
        .ADDI3_EN     (ADDI3_EN),
        .ADDI3_OPCODE (ADDI3_OPCODE)
    ) u_class_dec (
        .op_code  (op_code),
        .op_class (op_class),
        .legal    (legal)
    );

    assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Sticky trap flag, set as the FSM moves into the halt state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         illegal <= 1'b0;
        else if (state_next == S_ILLEGAL)  illegal <= 1'b1;
    end

    always_comb begin
        state_next = state;
        pc_update  = 1'b0;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        branch     = 1'b0;

        case (state)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = rdy;
                pc_update  = rdy;
                if (rdy) state_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                if (!legal)                             state_next = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
                else if (op_class.load || op_class.store) state_next = S_MEMADR;
                else if (op_class.r_alu)                state_next = S_EXEC_R;
                else if (op_class.i_alu || op_class.addi3) state_next = S_EXEC_I;
                else if (op_class.jal)                  state_next = S_JAL;
                else if (op_class.jalr)                 state_next = S_JALR;
                else                                    state_next = S_BRANCH;
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                state_next = op_class.store ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                if (rdy) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (rdy) state_next = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                alu_op     = op_class.addi3 ? ALUOP_ADDI3 : ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_update  = 1'b1;
                state_next = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                state_next = S_JALR_PC;
            end
            // ALUOut holds rs1+imm from S_JALR; ALU meanwhile forms oldPC+4.
            S_JALR_PC: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_update  = 1'b1;
                state_next = S_ALUWB;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALUOP_SUB;
                branch     = 1'b1;
                state_next = S_FETCH;
            end
            S_ILLEGAL: state_next = S_ILLEGAL;
            default:   state_next = S_FETCH;
        endcase

        pc_write = pc_update | (branch & zero);

        // Reset silences every strobe immediately, not at the next edge.
        if (reset) begin
            pc_write   = 1'b0;
            adr_src    = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            result_src = RES_ALUOUT;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_RS2;
            alu_op     = ALUOP_ADD;
            branch     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Directed bench for multicycle_main_controller: per-cycle output vectors
// for each instruction class, memory stalls, traps and async reset.
module tb_multicycle_main_controller;

    // {pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
    //  result_src, alu_src_a, alu_src_b, alu_op, branch, illegal}
    localparam logic [15:0] V_ZERO    = 16'h0000;
    localparam logic [15:0] V_FETCH_R = {1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_FETCH_W = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_MEMADR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_MEMREAD = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_MEMWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_MEMWR   = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_EXEC_R  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,1'b0,1'b0};
    localparam logic [15:0] V_EXEC_I  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b10,1'b0,1'b0};
    localparam logic [15:0] V_EXEC_I3 = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b11,1'b0,1'b0};
    localparam logic [15:0] V_ALUWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_JAL     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_JALR    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_JALR_PC = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,2'b00,1'b0,1'b0};
    localparam logic [15:0] V_BR_T    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01,1'b1,1'b0};
    localparam logic [15:0] V_BR_N    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01,1'b1,1'b0};
    localparam logic [15:0] V_ILLEGAL = 16'h0001;

    localparam logic [6:0] OPC_LW    = 7'b0000011;
    localparam logic [6:0] OPC_SW    = 7'b0100011;
    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_ADDI3 = 7'b0000010;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BEQ   = 7'b1100011;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op_code;
    logic       zero;
    logic       mem_ready;

    logic       d1_pc_write, d1_adr_src, d1_mem_read, d1_mem_write, d1_ir_write, d1_reg_write;
    logic [1:0] d1_result_src, d1_alu_src_a, d1_alu_src_b, d1_alu_op;
    logic       d1_branch, d1_illegal;
    logic       d2_pc_write, d2_adr_src, d2_mem_read, d2_mem_write, d2_ir_write, d2_reg_write;
    logic [1:0] d2_result_src, d2_alu_src_a, d2_alu_src_b, d2_alu_op;
    logic       d2_branch, d2_illegal;

    logic [15:0] obs1, obs2;
    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    multicycle_main_controller dut1 (
        .clk(clk), .reset(reset), .op_code(op_code), .zero(zero), .mem_ready(mem_ready),
        .pc_write(d1_pc_write), .adr_src(d1_adr_src), .mem_read(d1_mem_read),
        .mem_write(d1_mem_write), .ir_write(d1_ir_write), .reg_write(d1_reg_write),
        .result_src(d1_result_src), .alu_src_a(d1_alu_src_a), .alu_src_b(d1_alu_src_b),
        .alu_op(d1_alu_op), .branch(d1_branch), .illegal(d1_illegal)
    );

    multicycle_main_controller #(
        .MEM_HANDSHAKE(1'b0), .ADDI3_EN(1'b0), .ADDI3_OPCODE(7'b0000010), .ILLEGAL_HALT(1'b1)
    ) dut2 (
        .clk(clk), .reset(reset), .op_code(op_code), .zero(zero), .mem_ready(mem_ready),
        .pc_write(d2_pc_write), .adr_src(d2_adr_src), .mem_read(d2_mem_read),
        .mem_write(d2_mem_write), .ir_write(d2_ir_write), .reg_write(d2_reg_write),
        .result_src(d2_result_src), .alu_src_a(d2_alu_src_a), .alu_src_b(d2_alu_src_b),
        .alu_op(d2_alu_op), .branch(d2_branch), .illegal(d2_illegal)
    );

    assign obs1 = {d1_pc_write, d1_adr_src, d1_mem_read, d1_mem_write, d1_ir_write, d1_reg_write,
                   d1_result_src, d1_alu_src_a, d1_alu_src_b, d1_alu_op, d1_branch, d1_illegal};
    assign obs2 = {d2_pc_write, d2_adr_src, d2_mem_read, d2_mem_write, d2_ir_write, d2_reg_write,
                   d2_result_src, d2_alu_src_a, d2_alu_src_b, d2_alu_op, d2_branch, d2_illegal};

    // Leaves the bench 1 time unit after a rising edge with reset just released.
    task automatic apply_reset();
        reset = 1'b1; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        op_code = OPC_LW; mem_ready = 1'b1; zero = 1'b1;
        #1;
        checks++;
        if (obs1 !== V_ZERO) begin $display("FAIL reset_dut1: got %h expected %h", obs1, V_ZERO); fails++; end
        checks++;
        if (obs2 !== V_ZERO) begin $display("FAIL reset_dut2: got %h expected %h", obs2, V_ZERO); fails++; end
    endtask

    task automatic test_r_type();
        logic [15:0] ev [5];
        logic        rv [5];
        ev = '{V_FETCH_R, V_DECODE, V_EXEC_R, V_ALUWB, V_FETCH_R};
        rv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        op_code = OPC_R;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rv[i]; #1;
            checks++;
            if (obs1 !== ev[i]) begin $display("FAIL r_type step %0d: got %h expected %h", i, obs1, ev[i]); fails++; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        logic [15:0] ev [10];
        logic        rv [10];
        ev = '{V_FETCH_W, V_FETCH_R, V_DECODE, V_MEMADR, V_MEMREAD,
               V_MEMREAD, V_MEMREAD, V_MEMREAD, V_MEMWB, V_FETCH_R};
        rv = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        apply_reset();
        op_code = OPC_LW;
        for (int i = 0; i < 10; i++) begin
            mem_ready = rv[i]; #1;
            checks++;
            if (obs1 !== ev[i]) begin $display("FAIL lw_wait step %0d: got %h expected %h", i, obs1, ev[i]); fails++; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        logic [15:0] ev [7];
        logic        zv [7];
        ev = '{V_FETCH_R, V_DECODE, V_BR_T, V_FETCH_R, V_DECODE, V_BR_N, V_FETCH_R};
        zv = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        apply_reset();
        op_code = OPC_BEQ;
        for (int i = 0; i < 7; i++) begin
            zero = zv[i]; #1;
            checks++;
            if (obs1 !== ev[i]) begin $display("FAIL branch step %0d: got %h expected %h", i, obs1, ev[i]); fails++; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addi3_itype();
        logic [15:0] ev [9];
        logic [6:0]  ov [9];
        ev = '{V_FETCH_R, V_DECODE, V_EXEC_I3, V_ALUWB, V_FETCH_R, V_DECODE, V_EXEC_I, V_ALUWB, V_FETCH_R};
        ov = '{OPC_ADDI3, OPC_ADDI3, OPC_ADDI3, OPC_ADDI3, OPC_I, OPC_I, OPC_I, OPC_I, OPC_I};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            op_code = ov[i]; #1;
            checks++;
            if (obs1 !== ev[i]) begin $display("FAIL addi3_itype step %0d: got %h expected %h", i, obs1, ev[i]); fails++; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jalr_jal();
        logic [15:0] ev [10];
        logic [6:0]  ov [10];
        ev = '{V_FETCH_R, V_DECODE, V_JALR, V_JALR_PC, V_ALUWB, V_FETCH_R, V_DECODE, V_JAL, V_ALUWB, V_FETCH_R};
        ov = '{OPC_JALR, OPC_JALR, OPC_JALR, OPC_JALR, OPC_JALR, OPC_JAL, OPC_JAL, OPC_JAL, OPC_JAL, OPC_JAL};
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            op_code = ov[i]; #1;
            checks++;
            if (obs1 !== ev[i]) begin $display("FAIL jalr_jal step %0d: got %h expected %h", i, obs1, ev[i]); fails++; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        logic [15:0] ev [13];
        ev = '{V_FETCH_R, V_DECODE, V_ILLEGAL, V_ILLEGAL, V_ILLEGAL, V_ILLEGAL, V_ILLEGAL,
               V_ILLEGAL, V_ILLEGAL, V_ILLEGAL, V_ILLEGAL, V_ILLEGAL, V_ILLEGAL};
        apply_reset();
        op_code = OPC_ADDI3;
        for (int i = 0; i < 13; i++) begin
            mem_ready = (i % 2) == 1;
            zero      = (i % 3) == 0;
            #1;
            checks++;
            if (obs2 !== ev[i]) begin $display("FAIL illegal step %0d: got %h expected %h", i, obs2, ev[i]); fails++; end
            @(posedge clk); #1;
        end
        reset = 1'b1; #1;
        checks++;
        if (obs2 !== V_ZERO) begin $display("FAIL illegal_clear: got %h expected %h", obs2, V_ZERO); fails++; end
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b0; zero = 1'b0; #1;
        checks++;
        if (obs2 !== V_FETCH_R) begin $display("FAIL illegal_refetch: got %h expected %h", obs2, V_FETCH_R); fails++; end
    endtask

    task automatic test_sw_reset();
        logic [15:0] ev [9];
        logic        rv [9];
        ev = '{V_FETCH_R, V_DECODE, V_MEMADR, V_MEMWR, V_FETCH_R, V_DECODE, V_MEMADR, V_MEMWR, V_MEMWR};
        rv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        apply_reset();
        op_code = OPC_SW;
        for (int i = 0; i < 9; i++) begin
            mem_ready = rv[i]; #1;
            checks++;
            if (obs1 !== ev[i]) begin $display("FAIL sw step %0d: got %h expected %h", i, obs1, ev[i]); fails++; end
            @(posedge clk); #1;
        end
        #2;
        reset = 1'b1; #1;
        checks++;
        if (obs1 !== V_ZERO) begin $display("FAIL sw_async_reset: got %h expected %h", obs1, V_ZERO); fails++; end
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b1; #1;
        checks++;
        if (obs1 !== V_FETCH_R) begin $display("FAIL sw_after_reset_fetch: got %h expected %h", obs1, V_FETCH_R); fails++; end
        @(posedge clk); #1;
        checks++;
        if (obs1 !== V_DECODE) begin $display("FAIL sw_after_reset_decode: got %h expected %h", obs1, V_DECODE); fails++; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; op_code = 7'd0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_r_type();
        test_lw_wait();
        test_branch();
        test_addi3_itype();
        test_jalr_jal();
        test_illegal();
        test_sw_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_main_controller.md
Name: multicycle_main_controller

Overview:
- Main-control FSM for the multi-cycle RISC-V core; successor to the single-cycle combinational main controller.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath mux selects, register, IR and PC enables, the memory strobes and ALUOp to the existing ALU decoder.
- Adds a memory ready handshake, jalr, I-type ALU, a parametrised custom addi3 opcode and illegal-opcode trapping.

Parameters:
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_ready; 0 = memory completes in one cycle (mem_ready ignored).
- ADDI3_EN, 1: 1 = ADDI3_OPCODE is legal and executes with ALUOp 2'b11; 0 = it is illegal.
- ADDI3_OPCODE, 7'b0000010: opcode of the custom addi3 instruction.
- ILLEGAL_HALT, 1: 1 = an illegal opcode enters S_ILLEGAL permanently; 0 = it is treated as a NOP and the FSM returns to S_FETCH.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high
- op_code  in  7  instr[6:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- pc_write  out  1  PC enable; equals pc_update | (branch & zero)
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register and oldPC enable
- reg_write  out  1  register file write enable
- result_src  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4
- alu_op  out  2  00 = add, 01 = sub/branch, 10 = funct decode, 11 = addi3
- branch  out  1  branch-compare state
- illegal  out  1  sticky illegal-opcode flag

Behaviour:
- The state register is 4 bits and the only sequential logic apart from illegal.
- Outputs are Moore-decoded from state; ir_write and pc_update are additionally gated by mem_ready.
- Every output not listed for a state is 0.
- While reset is high: state = S_FETCH, illegal = 0, all outputs forced to 0.
- The first fetch occurs in the first cycle after reset deasserts.
- "rdy" below means mem_ready when MEM_HANDSHAKE=1, and constant 1 otherwise.

States (listed outputs, then transition):
- S_FETCH: adr_src=0, mem_read=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, ir_write=rdy, pc_update=rdy. Stays while !rdy, else -> S_DECODE.
- S_DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch/jal target into ALUOut). Next state by op_code:
  - 0000011 or 0100011 -> S_MEMADR
  - 0110011 -> S_EXEC_R
  - 0010011, or ADDI3_OPCODE with ADDI3_EN=1 -> S_EXEC_I
  - 1101111 -> S_JAL
  - 1100111 -> S_JALR
  - 1100011 -> S_BRANCH
  - anything else -> S_ILLEGAL if ILLEGAL_HALT=1, else S_FETCH
- S_MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. -> S_MEMREAD for lw, S_MEMWRITE for sw.
- S_MEMREAD: adr_src=1, mem_read=1. Holds until rdy, then -> S_MEMWB.
- S_MEMWB: result_src=01, reg_write=1. -> S_FETCH.
- S_MEMWRITE: adr_src=1, mem_write=1. Holds until rdy, then -> S_FETCH.
- S_EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10. -> S_ALUWB.
- S_EXEC_I: alu_src_a=10, alu_src_b=01; alu_op=11 when op_code==ADDI3_OPCODE, else 10. -> S_ALUWB.
- S_ALUWB: result_src=00, reg_write=1. -> S_FETCH.
- S_JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1. -> S_ALUWB (writes oldPC+4).
- S_JALR: alu_src_a=10, alu_src_b=01, alu_op=00. -> S_JALR_PC.
- S_JALR_PC: alu_src_a=01, alu_src_b=10, result_src=00, pc_update=1. -> S_ALUWB. Clearing the target LSB is the datapath's job.
- S_BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1. -> S_FETCH.
- S_ILLEGAL: all outputs 0, illegal=1. Self-loop until reset.

Boundary rules:
- mem_write and mem_read are never high in the same cycle.
- mem_ready arriving in a non-memory state is ignored.
- Asserting reset mid-instruction aborts it immediately with no further strobes.
- illegal sets on entry to S_ILLEGAL and clears only on reset.
- Unused state encodings recover to S_FETCH.
- Cycles per instruction with zero-wait memory: lw 5, sw 4, R/I 4, jal 4, jalr 5, beq 3.

Decomposition:
- Package core_ctrl_pkg holds:
  - opcode constants
  - the state enum with fixed 4-bit encodings
  - result_src, alu_src_a, alu_src_b and alu_op encodings, shared with the datapath and the ALU decoder
- One sub-module: opcode_class_dec, combinational, op_code -> one-hot instruction class plus legal flag, parametrised by ADDI3_EN and ADDI3_OPCODE.
- The FSM and output decode stay in this module.

Test Plan:
- Reset released, mem_ready=1, op add (0110011): states FETCH, DECODE, EXEC_R, ALUWB, FETCH. reg_write=1 only in cycle 4; alu_op=10 in cycle 3.
- lw with mem_ready low for 3 cycles in MEMREAD: MEMREAD held 4 cycles with mem_read=1 and adr_src=1. reg_write=1 with result_src=01 exactly one cycle after ready.
- beq, zero=1 then zero=0: pc_write=1 in the BRANCH cycle only when zero=1. Each instruction takes 3 cycles.
- ADDI3_EN=1, op 0000010: alu_op=11 in EXEC_I. With ADDI3_EN=0 and ILLEGAL_HALT=1: FSM enters S_ILLEGAL, illegal=1, all strobes 0 for 10 further cycles.
- jalr: pc_update=1 in S_JALR_PC, then reg_write=1 with result_src=00. Total 5 cycles.
- Reset asserted asynchronously mid-S_MEMWRITE: mem_write drops in the same cycle, state=S_FETCH, illegal=0.
